// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR coefficient loader: state encoding,
// coefficient word type and the offset-binary to two's-complement conversion.
package fir_pkg;

    localparam int NTAPS_DEF = 175;
    localparam int CW_DEF    = 16;

    typedef logic [CW_DEF-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_SWAP
    } ld_state_t;

    // Offset-binary places 0.0 at mid-scale, so flipping the MSB yields two's complement.
    function automatic coef_t ob2tc(input coef_t ob);
        return ob ^ {1'b1, {(CW_DEF-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fir_coef_loader_bank.sv
// Double-buffered coefficient storage: one write port into either bank (plus a
// mirror address for symmetric loads) and a registered read port on the active bank.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int CW    = CW_DEF,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic          we_m,
    input  logic [AW-1:0] waddr_m,
    input  logic [CW-1:0] wdata,
    input  logic          rd_bank,
    input  logic          loaded,
    input  logic [AW-1:0] rd_addr,
    output logic [CW-1:0] rd_data
);

    logic [CW-1:0] mem0 [NTAPS];
    logic [CW-1:0] mem1 [NTAPS];
    logic [CW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            if (wbank) mem1[waddr] <= wdata;
            else       mem0[waddr] <= wdata;
        end
        if (we_m) begin
            if (wbank) mem1[waddr_m] <= wdata;
            else       mem0[waddr_m] <= wdata;
        end
    end

    // Until the first swap the active bank holds garbage, so it reads as zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (!loaded || (rd_addr >= AW'(NTAPS))) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/fir_coef_loader.sv
// Runtime FIR coefficient loader: fills the shadow bank and swaps it active at a
// filter sample boundary. Define FIR_COEF_SYM_EN for half-length symmetric loads.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int CW    = CW_DEF,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [CW-1:0] s_data,
    input  logic          s_last,
    input  logic          swap_ok,
    input  logic [AW-1:0] rd_addr,
    output logic [CW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] checksum
);

`ifdef FIR_COEF_SYM_EN
    localparam int LEN = (NTAPS + 1) / 2;
`else
    localparam int LEN = NTAPS;
`endif

    ld_state_t     state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [CW-1:0] sum_q, sum_d;
    logic [CW-1:0] checksum_q, checksum_d;
    logic          active_q, active_d;
    logic          loaded_q, loaded_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          xfer;
    logic          at_end;
    logic          we_m;
    logic [AW-1:0] waddr_m;
    logic [CW-1:0] wdata;
    logic [CW-1:0] inc;

    assign wdata  = ob2tc(s_data);
    assign xfer   = (state_q == LOAD) && s_valid;
    assign at_end = (count_q == AW'(LEN - 1));

`ifdef FIR_COEF_SYM_EN
    // Non-centre words land on two taps and therefore count twice in the checksum.
    assign waddr_m = AW'(NTAPS - 1) - count_q;
    assign we_m    = xfer && (waddr_m != count_q);
    assign inc     = (waddr_m != count_q) ? (wdata << 1) : wdata;
`else
    assign waddr_m = count_q;
    assign we_m    = 1'b0;
    assign inc     = wdata;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            checksum_q <= '0;
            active_q   <= 1'b0;
            loaded_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            active_q   <= active_d;
            loaded_q   <= loaded_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sum_d      = sum_q;
        checksum_d = checksum_q;
        active_d   = active_q;
        loaded_d   = loaded_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    sum_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    count_d = count_q + 1'b1;
                    sum_d   = sum_q + inc;
                    if (at_end) begin
                        if (s_last) begin
                            state_d = WAIT_SWAP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_SWAP: begin
                if (swap_ok) begin
                    active_d   = ~active_q;
                    checksum_d = sum_q;
                    loaded_d   = 1'b1;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready  = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign checksum = checksum_q;

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .AW    (AW)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (xfer),
        .wbank   (~active_q),
        .waddr   (count_q),
        .we_m    (we_m),
        .waddr_m (waddr_m),
        .wdata   (wdata),
        .rd_bank (active_q),
        .loaded  (loaded_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: directed load scenarios with random
// data and handshake gaps, checked against a tap-array model of the active set.
module tb_fir_coef_loader;
    import fir_pkg::*;

    localparam int NTAPS = 175;
    localparam int CW    = 16;
    localparam int AW    = 8;
`ifdef FIR_COEF_SYM_EN
    localparam int LEN = (NTAPS + 1) / 2;
`else
    localparam int LEN = NTAPS;
`endif
    localparam int NEARLY = (LEN > 100) ? 100 : LEN / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          swap_ok = 1'b0;
    logic [CW-1:0] s_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          s_ready, busy, done, err;
    logic [CW-1:0] rd_data, checksum;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] stim  [NTAPS];
    logic [CW-1:0] m_act [NTAPS];
    bit            m_loaded = 1'b0;

    always #5 clk = ~clk;

    fir_coef_loader #(.NTAPS(NTAPS), .CW(CW), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .swap_ok  (swap_ok),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] exp_tap(input int a);
        if (!m_loaded || a >= NTAPS) return '0;
        return m_act[a];
    endfunction

    function automatic logic [CW-1:0] exp_sum();
        int s = 0;
        if (!m_loaded) return '0;
        for (int i = 0; i < NTAPS; i++) s += int'(m_act[i]);
        return s[CW-1:0];
    endfunction

    // Model of a completed swap: the offered words become the active tap set.
    task automatic commit();
        logic [CW-1:0] t;
        for (int k = 0; k < LEN; k++) begin
            t = stim[k] - 16'h8000;
            m_act[k] = t;
`ifdef FIR_COEF_SYM_EN
            m_act[NTAPS-1-k] = t;
`endif
        end
        m_loaded = 1'b1;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NTAPS; k++) stim[k] = CW'($urandom);
    endtask

    task automatic start_load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers words 0..n-1; s_last rides on index last_at (-1 for never).
    task automatic feed(input int n, input int last_at, input bit gaps);
        int idx = 0;
        int guard = 0;
        bit v;
        while (idx < n && guard < 4000) begin
            @(negedge clk);
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_valid = v;
            s_data  = stim[idx];
            s_last  = (idx == last_at);
            if (v && s_ready) idx++;
            guard++;
        end
        check("feed_count", idx, n);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic swap_now();
        swap_ok = 1'b1;
        @(negedge clk);
        swap_ok = 1'b0;
        check("swap_done", done, 1);
        check("swap_busy", busy, 0);
        commit();
        @(negedge clk);
        check("done_pulse", done, 0);
        check("checksum", checksum, exp_sum());
    endtask

    task automatic rd_check(input int a);
        rd_addr = AW'(a);
        @(negedge clk);
        check($sformatf("rd[%0d]", a), rd_data, exp_tap(a));
    endtask

    task automatic rd_all();
        for (int i = 0; i < NTAPS; i++) rd_check(i);
    endtask

    task automatic good_load(input bit gaps);
        start_load();
        feed(LEN, LEN - 1, gaps);
        check("wait_busy", busy, 1);
        check("wait_err", err, 0);
        swap_now();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_checksum", checksum, 0);
        check("rst_rd", rd_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // All mid-scale words: every tap reads zero
        for (int k = 0; k < NTAPS; k++) stim[k] = 16'h8000;
        good_load(1'b0);
        check("zero_checksum", checksum, 16'h0000);
        rd_all();

        // Ramp with delayed swap; old set stays visible until the swap
        for (int k = 0; k < NTAPS; k++) stim[k] = 16'h8000 + CW'(k);
        start_load();
        feed(LEN, LEN - 1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            rd_addr = AW'(5);
            @(negedge clk);
            check("hold_busy", busy, 1);
            check("hold_old_rd", rd_data, exp_tap(5));
        end
        swap_ok = 1'b1;
        start   = 1'b1;
        rd_addr = AW'(5);
        @(negedge clk);
        swap_ok = 1'b0;
        start   = 1'b0;
        check("ramp_done", done, 1);
        check("ramp_start_ignored", busy, 0);
        check("swap_cycle_rd_old", rd_data, exp_tap(5));
        commit();
        rd_check(5);
        check("ramp_tap5", rd_data, 16'd5);
`ifndef FIR_COEF_SYM_EN
        check("ramp_checksum", checksum, 16'h3B79);
`endif
        check("ramp_checksum_model", checksum, exp_sum());
        rd_all();

        // Early s_last: err, active set untouched, retry succeeds
        fill_rand();
        start_load();
        feed(NEARLY, NEARLY - 1, 1'b1);
        check("early_err", err, 1);
        check("early_busy", busy, 0);
        @(negedge clk);
        check("early_err_pulse", err, 0);
        check("early_checksum", checksum, exp_sum());
        rd_check(5);
        rd_check(NTAPS - 1);
        good_load(1'b1);
        rd_all();

        // Missing s_last on the final word, then a gapped good load
        fill_rand();
        start_load();
        feed(LEN, -1, 1'b0);
        check("nolast_err", err, 1);
        check("nolast_busy", busy, 0);
        check("nolast_checksum", checksum, exp_sum());
        rd_check(LEN - 1);
        fill_rand();
        good_load(1'b1);
        rd_all();

        // Out-of-range taps read zero
        rd_check(NTAPS);
        rd_check(255);

        // Reset in the middle of a load
        fill_rand();
        start_load();
        feed(60, -1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", s_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_checksum", checksum, 0);
        check("midrst_rd", rd_data, 0);
        reset = 1'b1;
        m_loaded = 1'b0;
        rd_check(0);
        rd_check(5);
        good_load(1'b1);
        rd_all();

`ifdef FIR_COEF_SYM_EN
        // Symmetric half-length load mirrors words around the centre tap
        for (int k = 0; k < NTAPS; k++) stim[k] = 16'h8001 + CW'(k);
        good_load(1'b0);
        rd_check(0);
        check("sym_tap0", rd_data, 16'd1);
        rd_check(NTAPS - 1);
        check("sym_tap174", rd_data, 16'd1);
        rd_check(87);
        check("sym_tap87", rd_data, 16'd88);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Writer side of the lowpass FIR coefficient bank: accepts a runtime stream of offset-binary coefficient words, converts them to two's complement and stores them in a shadow bank.
- On a complete, well-formed load, swaps the shadow bank to active at a filter-safe boundary.
- The filter reads taps from the active bank through a registered read port. The bank is double-buffered, so the filter never sees a partial set.

Parameters:
- NTAPS, 175, number of coefficients per set.
- CW, 16, coefficient width in bits.
- AW, 8, tap address width; must satisfy 2^AW >= NTAPS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE.
- s_valid  in  1  coefficient word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  CW  coefficient, offset-binary (0 = -1.0, 2^(CW-1) = 0.0).
- s_last  in  1  marks the final word of the set.
- swap_ok  in  1  filter is at a sample boundary; a bank swap is allowed this cycle.
- rd_addr  in  AW  tap index requested by the filter.
- rd_data  out  CW  active-bank coefficient at rd_addr, one-cycle latency.
- busy  out  1  high in LOAD or WAIT_SWAP.
- done  out  1  one-cycle pulse in the cycle after a swap.
- err  out  1  one-cycle pulse on a malformed load.
- checksum  out  CW  wrapping sum of the two's-complement words in the current active set.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State becomes IDLE; count clears to 0; active bank index becomes 0.
  - Outputs: s_ready=0, busy=0, done=0, err=0, checksum=0, rd_data=0.
  - Bank contents are not cleared, but the active bank reads as 0 until the first successful swap (tracked by a loaded flag).
  - Reset during LOAD or WAIT_SWAP aborts the load; the previous active set and flag are lost.
- Conversion: stored word = s_data XOR (1 << (CW-1)), i.e. offset-binary to two's complement by flipping the MSB.
- Shadow checksum: the running sum adds the stored word modulo 2^CW.
- States:
  - IDLE: s_ready=0. When start=1: count:=0, shadow sum:=0, go to LOAD.
  - LOAD: s_ready=1. A transfer occurs when s_valid & s_ready.
    - On transfer, write shadow[count]; count increments.
    - Transfer with s_last=1 and count==NTAPS-1: go to WAIT_SWAP.
    - Transfer with s_last=1 and count<NTAPS-1: pulse err and go to IDLE (early last).
    - Transfer with s_last=0 and count==NTAPS-1: pulse err and go to IDLE (missing last).
    - On err, the active bank and checksum are unchanged.
  - WAIT_SWAP: s_ready=0. When swap_ok=1:
    - Toggle the active bank index; checksum := shadow sum; set loaded.
    - Go to IDLE and pulse done in the next cycle.
- Filter read port:
  - rd_data is registered from active[rd_addr].
  - A swap takes effect for reads issued in the cycle after the swap cycle.
  - rd_addr >= NTAPS returns 0.
- start outside IDLE is ignored.
- A start pulse in the same cycle as done/err return is ignored, because the state is not yet IDLE.
- s_valid while s_ready=0 is not consumed; the upstream must hold its data.

Optional Feature:
- Macro: FIR_COEF_SYM_EN.
- Defined:
  - The set length is (NTAPS+1)/2 words (88 for 175).
  - Word k is stored at taps k and NTAPS-1-k; the centre tap is written once.
  - The s_last/count checks use the half length.
  - Checksum sums all NTAPS mirrored taps: each non-centre word counts twice, the centre word once.
- Undefined: full-length loading exactly as described above.

Decomposition:
- Package fir_pkg holds:
  - NTAPS_DEF=175, CW_DEF=16;
  - typedef coef_t = logic [CW-1:0];
  - enum ld_state_t {IDLE, LOAD, WAIT_SWAP};
  - function ob2tc (offset-binary to two's complement).
- One sub-module, fir_coef_bank: two NTAPS x CW arrays, one write port (bank, address, data), one registered read port on the active bank.

Test Plan:
- Load 175 words, all 16'h8000, with s_last on the final word; swap_ok=1 → done pulses; rd_data=0 for all taps; checksum=0.
- Load ramp s_data=16'h8000+k for k=0..174; hold swap_ok=0 for 10 cycles, then 1 → busy stays 1 and the old set is read until the swap; afterwards rd_addr=5 → rd_data=5 one cycle later; checksum=15225 (16'h3B79).
- s_last on word 100 → err pulse; state IDLE; active bank and checksum unchanged; start then retry succeeds.
- 175th word with s_last=0 → err; toggle s_valid randomly during a good load → exactly 175 transfers stored in order.
- reset=0 mid-LOAD at word 60 → all outputs 0 next cycle; rd_data=0 (not loaded); start honoured after release.
- FIR_COEF_SYM_EN: 88 words with s_data=16'h8001+k → tap 0 = tap 174 = 1, tap 87 = 88; s_last at word 88 is accepted.
